// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: size codes, FSM states and
// small size/alignment helpers.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE  = 2'b00;
    localparam logic [1:0] SZ_HALF  = 2'b01;
    localparam logic [1:0] SZ_WORD  = 2'b10;
    localparam logic [1:0] SZ_DWORD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        logic [3:0] n;
        case (size)
            SZ_BYTE: n = 4'd1;
            SZ_HALF: n = 4'd2;
            SZ_WORD: n = 4'd4;
            default: n = 4'd8;
        endcase
        return n;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] addr_lo);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = addr_lo[0];
            SZ_WORD: mis = |addr_lo[1:0];
            default: mis = |addr_lo;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dmem_responder_load_formatter.sv
// Assembles the fetched little-endian bytes of a load and sign- or zero-extends
// them to 64 bits according to the access size.
module load_formatter
    import dmem_pkg::*;
(
    input  logic [63:0] raw_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [63:0] data_o
);

    logic sx;

    always_comb begin
        data_o = raw_i;
        sx     = 1'b0;
        case (size_i)
            SZ_BYTE: begin
                sx     = ~unsigned_i & raw_i[7];
                data_o = {{56{sx}}, raw_i[7:0]};
            end
            SZ_HALF: begin
                sx     = ~unsigned_i & raw_i[15];
                data_o = {{48{sx}}, raw_i[15:0]};
            end
            SZ_WORD: begin
                sx     = ~unsigned_i & raw_i[31];
                data_o = {{32{sx}}, raw_i[31:0]};
            end
            default: data_o = raw_i;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Byte-addressed data memory behind a valid/ready request/response pair with
// programmable wait states. Optional macro MISALIGN_ERR_EN flags misaligned accesses.
module dmem_responder #(
    parameter int ADDRSIZE   = 8,
    parameter int WORDSIZE   = 64,
    parameter int WAITSTATES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [ADDRSIZE-1:0] req_addr,
    input  logic [WORDSIZE-1:0] req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [WORDSIZE-1:0] rsp_rdata,
    output logic                rsp_err
);

    import dmem_pkg::*;

    localparam int         MEM_BYTES = 2 ** ADDRSIZE;
    localparam logic [3:0] WS_LOAD   = 4'(WAITSTATES);

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [1:0]            size_q, size_d;
    logic                  uns_q, uns_d;
    logic [ADDRSIZE-1:0]   addr_q, addr_d;
    logic [WORDSIZE-1:0]   wdata_q, wdata_d;
    logic [WORDSIZE-1:0]   rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [7:0]            mem_q [MEM_BYTES];
    logic [7:0]            mem_d [MEM_BYTES];

    logic                  commit;
    logic                  misaligned;
    logic [3:0]            nbytes;
    logic [63:0]           fetch;
    logic [63:0]           formatted;

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign nbytes    = size_bytes(size_q);

`ifdef MISALIGN_ERR_EN
    assign misaligned = is_misaligned(size_q, addr_q[2:0]);
`else
    assign misaligned = 1'b0;
`endif

    // Addresses wrap modulo the memory size through the ADDRSIZE-bit index sum.
    always_comb begin
        fetch = '0;
        for (int i = 0; i < 8; i++) begin
            fetch[8*i +: 8] = mem_q[addr_q + ADDRSIZE'(i)];
        end
    end

    load_formatter u_load_formatter (
        .raw_i      (fetch),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .data_o     (formatted)
    );

    // WAIT spans WAITSTATES+1 cycles, so a request accepted at edge N enters
    // RESP (the commit edge) at edge N+WAITSTATES+1, including WAITSTATES=0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = WS_LOAD;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    commit  = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (commit) begin
            err_d   = misaligned;
            rdata_d = (we_q || misaligned) ? '0 : formatted;
        end
    end

    always_comb begin
        mem_d = mem_q;
        if (commit && we_q && !misaligned) begin
            for (int i = 0; i < 8; i++) begin
                if (4'(i) < nbytes) begin
                    mem_d[addr_q + ADDRSIZE'(i)] = wdata_q[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MEM_BYTES; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a byte-array reference model.
// Honours MISALIGN_ERR_EN the same way the design does.
module tb_dmem_responder;

    localparam int AW  = 8;
    localparam int DW  = 64;
    localparam int WS  = 2;
    localparam int MEMN = 256;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;

    logic [7:0] ref_mem [MEMN];
    int n_vec;
    int n_bad;

    dmem_responder #(
        .ADDRSIZE   (AW),
        .WORDSIZE   (DW),
        .WAITSTATES (WS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < MEMN; i++) ref_mem[i] = 8'h00;
    endtask

    task automatic model(input logic we, input logic [1:0] size, input logic uns,
                         input logic [7:0] addr, input logic [63:0] wdata,
                         output logic [63:0] rd, output logic er);
        int n;
        logic [63:0] v;
        bit mis;
        n   = 1 << size;
        v   = '0;
        mis = 1'b0;
`ifdef MISALIGN_ERR_EN
        mis = (int'(addr) % n) != 0;
`endif
        er = mis;
        rd = '0;
        if (!mis) begin
            if (we) begin
                for (int i = 0; i < n; i++) ref_mem[(int'(addr) + i) % MEMN] = wdata[8*i +: 8];
            end else begin
                for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[(int'(addr) + i) % MEMN];
                if (!uns && n < 8 && v[8*n-1]) begin
                    for (int b = 8*n; b < 64; b++) v[b] = 1'b1;
                end
                rd = v;
            end
        end
    endtask

    task automatic xact(input logic we, input logic [1:0] size, input logic uns,
                        input logic [7:0] addr, input logic [63:0] wdata,
                        output logic [63:0] rd, output logic er);
        logic [63:0] exp_rd;
        logic        exp_er;
        int          lat;
        int          hold;
        model(we, size, uns, addr, wdata, exp_rd, exp_er);
        @(negedge clk);
        chk("req_ready_idle", req_ready, 1);
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        req_valid    = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("req_ready_busy", req_ready, 0);
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, WS + 1);
        rd = rsp_rdata;
        er = rsp_err;
        chk("rdata", rd, exp_rd);
        chk("err", er, exp_er);
        hold = $urandom_range(0, 3);
        repeat (hold) begin
            @(negedge clk);
            chk("hold_rdata", rsp_rdata, rd);
            chk("hold_valid", rsp_valid, 1);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("valid_drop", rsp_valid, 0);
        chk("ready_back", req_ready, 1);
    endtask

    initial begin
        logic [63:0] rd;
        logic        er;
        logic [7:0]  a;
        n_vec = 0;
        n_bad = 0;
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        rsp_ready    = 1'b0;
        model_clear();
        #2 rst = 1'b0;
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        xact(0, 2'b11, 0, 8'h10, 0, rd, er);
        chk("ld_d_10", rd, 64'h0);
        chk("ld_d_10_err", er, 0);
        xact(1, 2'b11, 0, 8'h08, 64'h8877665544332211, rd, er);
        xact(0, 2'b00, 0, 8'h0F, 0, rd, er);
        chk("lb_0f", rd, 64'hFFFFFFFFFFFFFF88);
        xact(0, 2'b00, 1, 8'h0F, 0, rd, er);
        chk("lbu_0f", rd, 64'h88);
        xact(0, 2'b01, 0, 8'h08, 0, rd, er);
        chk("lh_08", rd, 64'h2211);

`ifdef MISALIGN_ERR_EN
        xact(0, 2'b10, 0, 8'h02, 0, rd, er);
        chk("lw_02_err", er, 1);
        chk("lw_02_rd", rd, 0);
        xact(1, 2'b01, 0, 8'h03, 64'h1234, rd, er);
        chk("sh_03_err", er, 1);
        xact(0, 2'b00, 1, 8'h03, 0, rd, er);
        chk("lbu_03", rd, 0);
`else
        xact(1, 2'b10, 0, 8'hFE, 64'hAABBCCDD, rd, er);
        xact(0, 2'b00, 1, 8'hFE, 0, rd, er);
        chk("wrap_fe", rd, 64'hDD);
        xact(0, 2'b00, 1, 8'hFF, 0, rd, er);
        chk("wrap_ff", rd, 64'hCC);
        xact(0, 2'b00, 1, 8'h00, 0, rd, er);
        chk("wrap_00", rd, 64'hBB);
        xact(0, 2'b00, 1, 8'h01, 0, rd, er);
        chk("wrap_01", rd, 64'hAA);
        xact(0, 2'b10, 0, 8'hFE, 0, rd, er);
        chk("wrap_lw_fe", rd, 64'hFFFFFFFFAABBCCDD);
`endif

        for (int t = 0; t < 80; t++) begin
            if ($urandom_range(0, 1) == 1) a = 8'($urandom_range(0, 31) + 240);
            else a = 8'($urandom_range(0, 255));
            xact(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 a, {$urandom, $urandom}, rd, er);
        end

        @(negedge clk);
        req_we    = 1'b1;
        req_size  = 2'b11;
        req_addr  = 8'h20;
        req_wdata = 64'hDEADBEEFCAFEF00D;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_req_ready", req_ready, 1);
        model_clear();
        @(negedge clk);
        rst = 1'b1;
        xact(0, 2'b11, 0, 8'h20, 0, rd, er);
        chk("midrst_ld_20", rd, 64'h0);
        xact(0, 2'b11, 0, 8'h08, 0, rd, er);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
